nock_dispatch: RTL
==================

Name: nock_dispatch

Overview:
- Upstream stage of the per-opcode function blocks (cell, increment, equals, slot, constant).
- On a dispatch request from memory traversal, it reads the formula cell of the node being reduced and decodes the opcode atom.
- It then drives the 3-bit function-select code, node address and formula word into the selected function block.
- It waits for that block's `finished`, then hands the block's return sys_func/state back to traversal.

Parameters:
- ADDR_W, 28, node address width (= `memory_addr_width).
- DATA_W, 64, memory word width (= `memory_data_width). Word layout: [63:58] flags, [57] hed_tag, [56] tel_tag, [55:28] hed, [27:0] tel. Tag ATOM=0, CELL=1.
- SEL_CONST, 3'd1, select code for opcode 1.
- SEL_SLOT, 3'd2, select code for opcode 0.
- SEL_CELL, 3'd3, select code for opcode 3 (= `MUX_CELL).
- SEL_INC, 3'd4, select code for opcode 4.
- SEL_EQ, 3'd5, select code for opcode 5.
- TIMEOUT, 1024, maximum cycles to wait for func_finished.

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-low
- dispatch_start  in  1  level request from traversal; a rising edge starts a dispatch
- dispatch_address  in  ADDR_W  node being reduced ([subject formula])
- dispatch_data  in  DATA_W  contents of dispatch_address
- dispatch_finished  out  1  dispatch complete, result or error valid
- dispatch_error  out  8  0=ok, 1=opcode is cell, 2=formula is atom, 3=unsupported opcode, 4=timeout
- ret_sys_func  out  4  sys func for traversal to resume
- ret_state  out  4  state for traversal to resume
- mem_ready  in  1  memory unit done
- read_data1  in  DATA_W  read data
- mem_execute  out  1  memory request
- address1  out  ADDR_W  memory address
- mem_func  out  2  memory function (`GET_CONTENTS only)
- func_select  out  3  function-block start code; 0 = none
- func_address  out  ADDR_W  node address given to the block
- func_data  out  DATA_W  formula word given to the block
- func_finished  in  1  function block finished
- func_return_sys_func  in  4  block's return sys func
- func_return_state  in  4  block's return state

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - timeout counter 0;
  - captured start/finished flops 0.
- Edge detection:
  - dispatch_start and func_finished are registered each clk.
  - A start is dispatch_start=1 with its previous value 0.
  - A finish is func_finished=1 with its previous value 0.
  - A start edge in any state forces a restart into IDLE handling: drop func_select, clear dispatch_finished/error, then begin READ_FORM.
- IDLE:
  - On start edge: if dispatch_data[tel_tag]=ATOM, set error 2 and go to ERROR.
  - Otherwise drive address1=dispatch_data tel, mem_func=`GET_CONTENTS, mem_execute=1; go to READ_FORM.
- READ_FORM:
  - mem_execute and mem_func are dropped to 0 on the cycle after issue.
  - Wait for mem_ready; latch read_data1 as the formula word; go to DECODE.
- DECODE (1 cycle):
  - hed_tag=CELL: error 1.
  - hed value 0/1/3/4/5: map to SEL_SLOT/SEL_CONST/SEL_CELL/SEL_INC/SEL_EQ.
  - Any other value, including 2 and 6-11: error 3. Only the full 28-bit hed value is compared.
  - On success go to LAUNCH; on error go to ERROR.
- LAUNCH:
  - Drive func_address=dispatch_address (latched at start) and func_data=latched formula word.
  - Drive func_select = mapped code; hold it through WAIT_FUNC.
  - func_address/func_data are stable from the same cycle func_select rises.
  - Go to WAIT_FUNC.
- WAIT_FUNC:
  - The counter increments each cycle.
  - On finish edge: latch func_return_sys_func/state into ret_*; func_select←0; go to DONE.
  - If the counter reaches TIMEOUT-1 with no finish: error 4, func_select←0, go to ERROR.
  - A finish and a timeout in the same cycle: the finish wins.
- DONE / ERROR:
  - dispatch_finished=1 and held.
  - On ERROR, ret_* are left at their previous values.
  - Remain until the next start edge.
- Latency: start edge to func_select valid is 3 cycles + memory latency (IDLE issue, READ_FORM wait, DECODE, LAUNCH).
- Memory bus is driven only in IDLE/READ_FORM. It is 0 otherwise, so the selected function block owns memory downstream.
- Reset mid-operation: immediate return to reset values; an in-flight memory request is abandoned.

Test Plan:
- Opcode 3 dispatch:
  - Stimulus: dispatch_data tel=0x10; mem word @0x10 has hed=3 (ATOM), tel=0x20 (CELL).
  - Response: one read of 0x10; func_select=3 with func_data=that word; after func_finished rises with ret sys_func=2, state=5, dispatch_finished=1, error 0, ret_sys_func=2, ret_state=5.
- Opcode 4 maps to func_select=4 and opcode 0 maps to 2.
- Unsupported opcode 7 -> error 3, func_select never nonzero, dispatch_finished=1.
- Cell-valued opcode (hed_tag=CELL) -> error 1.
- Atom formula (dispatch_data tel_tag=ATOM) -> error 2 with no memory request.
- Timeout: func_finished held 0 -> error 4 exactly TIMEOUT cycles after func_select rises; func_select returns to 0.
- Reset asserted during WAIT_FUNC -> all outputs 0 immediately; a new start edge dispatches normally.
- Restart: a new start edge while in DONE clears finished the next cycle and issues a fresh read.

Source files
------------

// File: rtl/nock_dispatch.sv
// nock_dispatch: fetches a node's formula, decodes its opcode atom and runs the matching function block
module nock_dispatch #(
    parameter int         ADDR_W    = 28,
    parameter int         DATA_W    = 64,
    parameter logic [2:0] SEL_CONST = 3'd1,
    parameter logic [2:0] SEL_SLOT  = 3'd2,
    parameter logic [2:0] SEL_CELL  = 3'd3,
    parameter logic [2:0] SEL_INC   = 3'd4,
    parameter logic [2:0] SEL_EQ    = 3'd5,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_start,
    input  logic [ADDR_W-1:0] dispatch_address,
    input  logic [DATA_W-1:0] dispatch_data,
    output logic              dispatch_finished,
    output logic [7:0]        dispatch_error,
    output logic [3:0]        ret_sys_func,
    output logic [3:0]        ret_state,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data1,
    output logic              mem_execute,
    output logic [ADDR_W-1:0] address1,
    output logic [1:0]        mem_func,
    output logic [2:0]        func_select,
    output logic [ADDR_W-1:0] func_address,
    output logic [DATA_W-1:0] func_data,
    input  logic              func_finished,
    input  logic [3:0]        func_return_sys_func,
    input  logic [3:0]        func_return_state
);
    localparam logic [1:0] GET_CONTENTS = 2'd1;
    localparam int CW = $clog2(TIMEOUT);
    localparam int TEL_TAG = 2 * ADDR_W;
    localparam int HED_TAG = 2 * ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, READ_FORM, DECODE, LAUNCH, WAIT_FUNC, DONE, ERROR} state_t;

    typedef struct packed {
        state_t            state;
        logic              start_prev;
        logic              fin_prev;
        logic [CW-1:0]     cnt;
        logic [ADDR_W-1:0] node;
        logic [DATA_W-1:0] form;
        logic [2:0]        sel;
        logic              finished;
        logic [7:0]        error;
        logic [3:0]        ret_sys_func;
        logic [3:0]        ret_state;
        logic              mem_execute;
        logic [ADDR_W-1:0] address1;
        logic [1:0]        mem_func;
        logic [2:0]        func_select;
        logic [ADDR_W-1:0] func_address;
        logic [DATA_W-1:0] func_data;
    } regs_t;

    regs_t r_q, r_d;
    logic start_edge, fin_edge, bad, is_cell;
    logic [ADDR_W-1:0] hed;
    logic [2:0] sel;
    logic unused_bits;

    assign start_edge = dispatch_start & ~r_q.start_prev;
    assign fin_edge = func_finished & ~r_q.fin_prev;
    assign is_cell = dispatch_data[TEL_TAG];
    assign hed = r_q.form[2*ADDR_W-1:ADDR_W];
    assign sel = hed == ADDR_W'(0) ? SEL_SLOT :
                 hed == ADDR_W'(1) ? SEL_CONST :
                 hed == ADDR_W'(3) ? SEL_CELL :
                 hed == ADDR_W'(4) ? SEL_INC :
                 hed == ADDR_W'(5) ? SEL_EQ : 3'd0;
    assign bad = r_q.form[HED_TAG] | (sel == 3'd0);
    assign unused_bits = ^{dispatch_data[DATA_W-1:TEL_TAG+1], dispatch_data[TEL_TAG-1:ADDR_W]};

    always_comb begin
        r_d = r_q;
        r_d.start_prev = dispatch_start;
        r_d.fin_prev = func_finished;
        if (start_edge) begin
            r_d.node = dispatch_address;
            r_d.func_select = '0;
            r_d.finished = ~is_cell;
            r_d.error = is_cell ? 8'd0 : 8'd2;
            r_d.mem_execute = is_cell;
            r_d.mem_func = is_cell ? GET_CONTENTS : 2'd0;
            r_d.address1 = is_cell ? dispatch_data[ADDR_W-1:0] : '0;
            r_d.state = is_cell ? READ_FORM : ERROR;
        end else begin
            case (r_q.state)
                READ_FORM: begin
                    r_d.mem_execute = 1'b0;
                    r_d.mem_func = 2'd0;
                    if (mem_ready) begin
                        r_d.form = read_data1;
                        r_d.address1 = '0;
                        r_d.state = DECODE;
                    end
                end
                DECODE: begin
                    r_d.sel = sel;
                    r_d.error = r_q.form[HED_TAG] ? 8'd1 : bad ? 8'd3 : 8'd0;
                    r_d.finished = bad;
                    r_d.state = bad ? ERROR : LAUNCH;
                end
                LAUNCH: begin
                    r_d.func_select = r_q.sel;
                    r_d.func_address = r_q.node;
                    r_d.func_data = r_q.form;
                    r_d.cnt = '0;
                    r_d.state = WAIT_FUNC;
                end
                WAIT_FUNC: begin
                    r_d.cnt = r_q.cnt + CW'(1);
                    if (fin_edge) begin
                        r_d.ret_sys_func = func_return_sys_func;
                        r_d.ret_state = func_return_state;
                        r_d.func_select = '0;
                        r_d.finished = 1'b1;
                        r_d.state = DONE;
                    end else if (r_q.cnt == CW'(TIMEOUT - 1)) begin
                        r_d.func_select = '0;
                        r_d.finished = 1'b1;
                        r_d.error = 8'd4;
                        r_d.state = ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= '0;
        else r_q <= r_d;
    end

    assign dispatch_finished = r_q.finished;
    assign dispatch_error = r_q.error;
    assign ret_sys_func = r_q.ret_sys_func;
    assign ret_state = r_q.ret_state;
    assign mem_execute = r_q.mem_execute;
    assign address1 = r_q.address1;
    assign mem_func = r_q.mem_func;
    assign func_select = r_q.func_select;
    assign func_address = r_q.func_address;
    assign func_data = r_q.func_data;
endmodule
